array_9_ctrl: RTL

- Request front-end that sits directly upstream of the 256x86 single-port, 2-lane masked SRAM macro (array_9_ext) and drives its RW0 port.
- Accepts read/write requests on a valid/ready port and issues at most one SRAM access per cycle.
- Captures 1-cycle-latency read data into an in-order response buffer with valid/ready backpressure.
- Protects read data from being overwritten by a later write to the same address, because macro rdata is combinational off the stored address.

---
 rtl/array_9_pkg.sv | 17 +
 rtl/array_9_resp_buf.sv | 84 ++++++++
 rtl/array_9_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/array_9_pkg.sv
// Shared defaults and types for the array_9 SRAM request front-end.
// Optional power-on clear sweep: ARRAY_9_CTRL_INIT_EN (see array_9_ctrl).
package array_9_pkg;

    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 86;
    localparam int LANES      = 2;
    localparam int LANE_W     = 43;
    localparam int RESP_DEPTH = 2;

    // Controller phase: clear sweep of the array, then normal request service.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/array_9_resp_buf.sv
// In-order circular response buffer. Head is presented combinationally from
// storage; pointers wrap modulo DEPTH. A push is only honoured when a slot is
// free (or one is freed by a simultaneous pop).
module array_9_resp_buf #(
    parameter int  DEPTH = 2,
    parameter int  W     = 86,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     head,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok_s, pop_ok_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_W'(DEPTH - 1)) begin
            r = {PTR_W{1'b0}};
        end else begin
            r = p + PTR_W'(1);
        end
        return r;
    endfunction

    // Next-state of storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop_ok_s  = pop && (count_q != {CNT_W{1'b0}});
        push_ok_s = push && ((count_q != CNT_W'(DEPTH)) || pop_ok_s);
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Buffer state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == {CNT_W{1'b0}});

endmodule

// File: rtl/array_9_ctrl.sv
// Request front-end for the 256x86 2-lane masked single-port SRAM (RW0).
// One access per cycle; read data (1-cycle latency) either falls through to
// the response port or is captured in an in-order buffer. Read credits count
// the in-flight read plus buffered words so the buffer can never overflow.
// Optional: define ARRAY_9_CTRL_INIT_EN to zero the whole array after reset.
module array_9_ctrl #(
    parameter int ADDR_W     = array_9_pkg::ADDR_W,
    parameter int DATA_W     = array_9_pkg::DATA_W,
    parameter int LANES      = array_9_pkg::LANES,
    parameter int RESP_DEPTH = array_9_pkg::RESP_DEPTH
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LANES-1:0]  req_mask,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [LANES-1:0]  sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              init_busy
);

    import array_9_pkg::*;

    localparam int CNT_W = $clog2(RESP_DEPTH + 1);

    logic              rd_pending_q, rd_pending_d;
    logic [CNT_W-1:0]  buf_count_s;
    logic              buf_empty_s;
    logic              buf_push_s, buf_pop_s;
    logic [DATA_W-1:0] buf_head_s;
    logic [CNT_W:0]    credits_s;
    logic              req_ready_s, accept_s, init_busy_s;
    logic              resp_valid_s;
    logic [DATA_W-1:0] resp_rdata_s;

`ifdef ARRAY_9_CTRL_INIT_EN
    ctrl_state_e       state_q, state_d;
    logic [ADDR_W-1:0] init_addr_q, init_addr_d;

    // Clear-sweep sequencing: one write per cycle, leave INIT after the last address.
    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        case (state_q)
            INIT: begin
                init_addr_d = init_addr_q + ADDR_W'(1);
                if (init_addr_q == {ADDR_W{1'b1}}) begin
                    state_d = RUN;
                end else begin
                    state_d = INIT;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d     = INIT;
                init_addr_d = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Sweep state register; any reset restarts the sweep from address 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= INIT;
            init_addr_q <= {ADDR_W{1'b0}};
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
        end
    end

    assign init_busy_s = (state_q == INIT);
`else
    assign init_busy_s = 1'b0;
`endif

    // Acceptance depends only on registered occupancy, never on resp_ready.
    always_comb begin
        credits_s   = {{CNT_W{1'b0}}, rd_pending_q} + {1'b0, buf_count_s};
        req_ready_s = reset_n && !init_busy_s &&
                      (req_write || (credits_s < (CNT_W + 1)'(RESP_DEPTH)));
        accept_s    = req_valid && req_ready_s;
        rd_pending_d = accept_s && !req_write;
    end

    // SRAM port drive: request fields pass straight through; sweep overrides.
    always_comb begin
        sram_en    = accept_s;
        sram_wmode = accept_s && req_write;
        sram_addr  = req_addr;
        sram_wmask = req_mask;
        sram_wdata = req_wdata;
`ifdef ARRAY_9_CTRL_INIT_EN
        if (init_busy_s) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = init_addr_q;
            sram_wmask = {LANES{1'b1}};
            sram_wdata = {DATA_W{1'b0}};
        end else begin
            sram_en    = accept_s;
            sram_wmode = accept_s && req_write;
        end
`endif
    end

    // Marks the cycle in which the SRAM presents data for an accepted read.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_pending_q <= 1'b0;
        end else begin
            rd_pending_q <= rd_pending_d;
        end
    end

    // Response steering: buffered head first, else fall-through of fresh SRAM data.
    always_comb begin
        resp_valid_s = 1'b0;
        resp_rdata_s = buf_head_s;
        buf_push_s   = 1'b0;
        buf_pop_s    = 1'b0;
        if (!buf_empty_s) begin
            resp_valid_s = 1'b1;
            resp_rdata_s = buf_head_s;
            buf_pop_s    = resp_ready;
            buf_push_s   = rd_pending_q;
        end else if (rd_pending_q) begin
            resp_valid_s = 1'b1;
            resp_rdata_s = sram_rdata;
            buf_push_s   = !resp_ready;
        end else begin
            resp_valid_s = 1'b0;
        end
    end

    array_9_resp_buf #(
        .DEPTH (RESP_DEPTH),
        .W     (DATA_W)
    ) u_resp_buf (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (buf_push_s),
        .pop     (buf_pop_s),
        .din     (sram_rdata),
        .head    (buf_head_s),
        .count   (buf_count_s),
        .empty   (buf_empty_s)
    );

    assign req_ready  = req_ready_s;
    assign resp_valid = resp_valid_s;
    assign resp_rdata = resp_rdata_s;
    assign init_busy  = init_busy_s;

endmodule
